// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl
//   Timekeeping and time-set controller for a 24 h HH:MM:SS digital clock.
//   An internal prescaler advances the BCD seconds; a small mode FSM driven
//   by single-cycle button pulses lets the user set hours and minutes, and a
//   blink phase produces blanking masks for the seven-segment multiplexer.
//
// Parameters
//   TICKS_PER_SEC  in_clk cycles per second (>= 1)
//   BLINK_DIV      in_clk cycles per half-period of the set-mode blink (>= 1)
//
// Optional build macro
//   ALARM_EN       adds alarm_h/alarm_m registers, states SET_AH/SET_AM and
//                  the alarm output pulse
//
// Ports
//   in_clk    system clock, all state changes on its rising edge
//   rst       synchronous active-low reset, priority over all inputs
//   btn_mode  one-cycle pulse, steps the mode FSM
//   btn_inc   one-cycle pulse, increments the selected field in set modes
//   h10..s1   BCD time digits (alarm value for h10..m1 in alarm-set modes)
//   mode      FSM state, also the debug view of the FSM
//   sec_tick  one-cycle pulse in the cycle after each second advance
//   alarm     (ALARM_EN only) one-cycle pulse when time reaches the alarm
//   blank_h   blank the hour digits
//   blank_m   blank the minute digits
//
// Input protocol: btn_mode and btn_inc are level-free one-cycle pulses
// sampled on every rising edge; there is no back-pressure. When both are
// high on the same edge, btn_mode wins and btn_inc is dropped. Every effect
// is visible on the outputs in the cycle after the sampling edge.

module clock_time_ctrl #(
    parameter int TICKS_PER_SEC = 1,
    parameter int BLINK_DIV     = 2
) (
    input  logic       in_clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] h10,
    output logic [3:0] h1,
    output logic [3:0] m10,
    output logic [3:0] m1,
    output logic [3:0] s10,
    output logic [3:0] s1,
    output logic [2:0] mode,
    output logic       sec_tick,
`ifdef ALARM_EN
    output logic       alarm,
`endif
    output logic       blank_h,
    output logic       blank_m
);

    // Counter widths; keep at least one bit so a divide-by-one still has a
    // legal register.
    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_SET_H = 3'd1,
        ST_SET_M = 3'd2
`ifdef ALARM_EN
        ,
        ST_SET_AH = 3'd3,
        ST_SET_AM = 3'd4
`endif
    } state_t;

    state_t        state, state_n;
    logic [7:0]    hr, hr_n;      // {tens, ones}
    logic [7:0]    mn, mn_n;
    logic [7:0]    sc, sc_n;
    logic [PW-1:0] presc, presc_n;
    logic [BW-1:0] bcnt, bcnt_n;
    logic          phase, phase_n;
    logic          tick_n;
`ifdef ALARM_EN
    logic [7:0]    al_h, al_h_n;
    logic [7:0]    al_m, al_m_n;
    logic          alarm_n;
`endif

    // BCD increment of an hour pair, 23 wraps to 00.
    function automatic logic [7:0] inc_hours(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h23)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // BCD increment of a minute/second pair, 59 wraps to 00.
    function automatic logic [7:0] inc_60(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h59)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    always_comb begin
        state_n = state;
        hr_n    = hr;
        mn_n    = mn;
        sc_n    = sc;
        presc_n = presc;
        bcnt_n  = bcnt;
        phase_n = phase;
        tick_n  = 1'b0;
`ifdef ALARM_EN
        al_h_n  = al_h;
        al_m_n  = al_m;
        alarm_n = 1'b0;
`endif

        if (btn_mode) begin
            case (state)
                ST_RUN:    state_n = ST_SET_H;
                ST_SET_H:  state_n = ST_SET_M;
`ifdef ALARM_EN
                ST_SET_M:  state_n = ST_SET_AH;
                ST_SET_AH: state_n = ST_SET_AM;
                ST_SET_AM: state_n = ST_RUN;
`else
                ST_SET_M:  state_n = ST_RUN;
`endif
                default:   state_n = ST_RUN;
            endcase
            // Any mode change restarts both the prescaler and the blink.
            presc_n = '0;
            bcnt_n  = '0;
            phase_n = 1'b0;
            if (state == ST_RUN)
                sc_n = 8'h00;
        end else if (state == ST_RUN) begin
            bcnt_n  = '0;
            phase_n = 1'b0;
            if (presc == PRESC_LAST) begin
                presc_n = '0;
                tick_n  = 1'b1;
                sc_n    = inc_60(sc);
                if (sc == 8'h59) begin
                    mn_n = inc_60(mn);
                    if (mn == 8'h59)
                        hr_n = inc_hours(hr);
                end
`ifdef ALARM_EN
                alarm_n = (sc_n == 8'h00) && (hr_n == al_h) && (mn_n == al_m);
`endif
            end else begin
                presc_n = presc + PW'(1);
            end
        end else begin
            presc_n = '0;
            if (btn_inc) begin
                case (state)
                    ST_SET_H:  hr_n   = inc_hours(hr);
                    ST_SET_M:  mn_n   = inc_60(mn);
`ifdef ALARM_EN
                    ST_SET_AH: al_h_n = inc_hours(al_h);
                    ST_SET_AM: al_m_n = inc_60(al_m);
`endif
                    default: ;
                endcase
                // Show the new value steadily before blinking resumes.
                bcnt_n  = '0;
                phase_n = 1'b0;
            end else if (bcnt == BLINK_LAST) begin
                bcnt_n  = '0;
                phase_n = ~phase;
            end else begin
                bcnt_n = bcnt + BW'(1);
            end
        end
    end

    always_ff @(posedge in_clk) begin
        if (!rst) begin
            state    <= ST_RUN;
            hr       <= 8'h00;
            mn       <= 8'h00;
            sc       <= 8'h00;
            presc    <= '0;
            bcnt     <= '0;
            phase    <= 1'b0;
            sec_tick <= 1'b0;
`ifdef ALARM_EN
            al_h     <= 8'h00;
            al_m     <= 8'h00;
            alarm    <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            hr       <= hr_n;
            mn       <= mn_n;
            sc       <= sc_n;
            presc    <= presc_n;
            bcnt     <= bcnt_n;
            phase    <= phase_n;
            sec_tick <= tick_n;
`ifdef ALARM_EN
            al_h     <= al_h_n;
            al_m     <= al_m_n;
            alarm    <= alarm_n;
`endif
        end
    end

    // Outputs are pure functions of registers, so nothing combinational
    // from the buttons reaches the display.
`ifdef ALARM_EN
    logic show_alarm;
    assign show_alarm = (state == ST_SET_AH) || (state == ST_SET_AM);
    assign {h10, h1} = show_alarm ? al_h : hr;
    assign {m10, m1} = show_alarm ? al_m : mn;
    assign blank_h   = phase && ((state == ST_SET_H) || (state == ST_SET_AH));
    assign blank_m   = phase && ((state == ST_SET_M) || (state == ST_SET_AM));
`else
    assign {h10, h1} = hr;
    assign {m10, m1} = mn;
    assign blank_h   = phase && (state == ST_SET_H);
    assign blank_m   = phase && (state == ST_SET_M);
`endif
    assign {s10, s1} = sc;
    assign mode      = state;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Testbench for clock_time_ctrl: a 4-tick-per-second instance driven by
// scenario tasks and random buttons against a seconds-of-day model, plus a
// 1-tick-per-second instance checked for a tick on every cycle.

module tb_clock_time_ctrl;

    localparam int TPS = 4;
    localparam int BD  = 2;

    logic       in_clk;
    logic       rst;
    logic       btn_mode;
    logic       btn_inc;
    logic [3:0] h10, h1, m10, m1, s10, s1;
    logic [2:0] mode;
    logic       sec_tick, blank_h, blank_m;

    logic       t1_zero;
    logic [3:0] t1_h10, t1_h1, t1_m10, t1_m1, t1_s10, t1_s1;
    logic [2:0] t1_mode;
    logic       t1_tick, t1_blank_h, t1_blank_m;
`ifdef ALARM_EN
    logic       alarm, t1_alarm;
`endif

    int errors = 0;
    int checks = 0;

    logic [29:0] exp_q[$];
    logic [29:0] dut_vec;
    assign dut_vec = {h10, h1, m10, m1, s10, s1, mode, sec_tick, blank_h, blank_m};

    // ---------------- clock / reset ----------------
    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    clock_time_ctrl #(.TICKS_PER_SEC(TPS), .BLINK_DIV(BD)) u_dut (
        .in_clk  (in_clk),
        .rst     (rst),
        .btn_mode(btn_mode),
        .btn_inc (btn_inc),
        .h10     (h10),
        .h1      (h1),
        .m10     (m10),
        .m1      (m1),
        .s10     (s10),
        .s1      (s1),
        .mode    (mode),
        .sec_tick(sec_tick),
`ifdef ALARM_EN
        .alarm   (alarm),
`endif
        .blank_h (blank_h),
        .blank_m (blank_m)
    );

    clock_time_ctrl #(.TICKS_PER_SEC(1), .BLINK_DIV(BD)) u_t1 (
        .in_clk  (in_clk),
        .rst     (rst),
        .btn_mode(t1_zero),
        .btn_inc (t1_zero),
        .h10     (t1_h10),
        .h1      (t1_h1),
        .m10     (t1_m10),
        .m1      (t1_m1),
        .s10     (t1_s10),
        .s1      (t1_s1),
        .mode    (t1_mode),
        .sec_tick(t1_tick),
`ifdef ALARM_EN
        .alarm   (t1_alarm),
`endif
        .blank_h (t1_blank_h),
        .blank_m (t1_blank_m)
    );

    // ---------------- reference model ----------------
    // Time kept as seconds of the day; the prescaler as edges since RUN was
    // entered; the blink as edges since the last mode change or increment.
    int m_time, m_mode, m_since, m_age;
    bit m_tick;

    task automatic model_step(input bit bm, input bit bi, input bit rv);
        int h, mi, s;
        if (!rv) begin
            m_time = 0; m_mode = 0; m_since = 0; m_age = 0; m_tick = 0;
        end else if (bm) begin
            m_mode = (m_mode + 1) % 3;
            if (m_mode == 1) m_time = m_time - (m_time % 60);
            m_since = 0; m_age = 0; m_tick = 0;
        end else if (m_mode == 0) begin
            m_since++;
            m_tick = ((m_since % TPS) == 0);
            if (m_tick) m_time = (m_time + 1) % 86400;
        end else begin
            m_tick = 0;
            if (bi) begin
                h = m_time / 3600; mi = (m_time / 60) % 60; s = m_time % 60;
                if (m_mode == 1) h = (h + 1) % 24;
                else mi = (mi + 1) % 60;
                m_time = h * 3600 + mi * 60 + s;
                m_age = 0;
            end else begin
                m_age++;
            end
        end
    endtask

    function automatic logic [29:0] model_vec();
        int h, mi, s;
        logic ph;
        h = m_time / 3600; mi = (m_time / 60) % 60; s = m_time % 60;
        ph = (m_mode != 0) && (((m_age / BD) % 2) == 1);
        return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10),
                4'(s / 10), 4'(s % 10), 3'(m_mode), m_tick,
                ph && (m_mode == 1), ph && (m_mode == 2)};
    endfunction

    // ---------------- driver ----------------
    task automatic step(input bit bm, input bit bi, input bit rv);
        btn_mode = bm; btn_inc = bi; rst = rv;
        @(posedge in_clk);
        #1;
        model_step(bm, bi, rv);
        exp_q.push_back(model_vec());
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [29:0] e;
        step(0, 0, 0);
        e = exp_q.pop_front();
        step(0, 0, 0);
        e = exp_q.pop_front();
        checks++;
        if (dut_vec !== 30'd0) begin
            errors++; $display("FAIL reset_state: got %h exp %h", dut_vec, 30'd0);
        end
        checks++;
        if (dut_vec !== e) begin
            errors++; $display("FAIL reset_model: got %h exp %h", dut_vec, e);
        end
    endtask

    task automatic test_reset_mid_count();
        logic [29:0] e;
        for (int i = 0; i < 3 * TPS; i++) begin
            step(0, 0, 1);
            e = exp_q.pop_front();
            checks++;
            if (dut_vec !== e) begin
                errors++; $display("FAIL run_to_3s cyc %0d: got %h exp %h", i, dut_vec, e);
            end
        end
        checks++;
        if ({s10, s1} !== 8'h03) begin
            errors++; $display("FAIL at_3s: got %h exp 03", {s10, s1});
        end
        step(0, 0, 0);
        e = exp_q.pop_front();
        checks++;
        if (dut_vec !== 30'd0) begin
            errors++; $display("FAIL mid_reset: got %h exp %h", dut_vec, 30'd0);
        end
        for (int i = 1; i <= TPS; i++) begin
            step(0, 0, 1);
            e = exp_q.pop_front();
            checks++;
            if (sec_tick !== (i == TPS)) begin
                errors++; $display("FAIL first_tick cyc %0d: got %b exp %b", i, sec_tick, i == TPS);
            end
            checks++;
            if (dut_vec !== e) begin
                errors++; $display("FAIL after_reset cyc %0d: got %h exp %h", i, dut_vec, e);
            end
        end
    endtask

    task automatic test_rollover();
        logic [29:0] e;
        step(1, 0, 1); e = exp_q.pop_front();
        for (int i = 0; i < 23; i++) begin step(0, 1, 1); e = exp_q.pop_front(); end
        step(1, 0, 1); e = exp_q.pop_front();
        for (int i = 0; i < 59; i++) begin step(0, 1, 1); e = exp_q.pop_front(); end
        checks++;
        if (dut_vec !== e) begin
            errors++; $display("FAIL set_2359: got %h exp %h", dut_vec, e);
        end
        step(1, 0, 1); e = exp_q.pop_front();
        for (int i = 0; i < 59 * TPS; i++) begin
            step(0, 0, 1);
            e = exp_q.pop_front();
            checks++;
            if (dut_vec !== e) begin
                errors++; $display("FAIL run_up cyc %0d: got %h exp %h", i, dut_vec, e);
            end
        end
        checks++;
        if ({h10, h1, m10, m1, s10, s1} !== 24'h235959) begin
            errors++; $display("FAIL at_235959: got %h exp 235959", {h10, h1, m10, m1, s10, s1});
        end
        for (int i = 0; i < TPS; i++) begin step(0, 0, 1); e = exp_q.pop_front(); end
        checks++;
        if ({h10, h1, m10, m1, s10, s1, sec_tick} !== 25'h0000001) begin
            errors++; $display("FAIL rollover: got %h tick %b exp 000000 tick 1",
                               {h10, h1, m10, m1, s10, s1}, sec_tick);
        end
    endtask

    task automatic test_field_wrap();
        logic [29:0] e;
        step(1, 0, 1); e = exp_q.pop_front();
        for (int i = 0; i < 23; i++) begin step(0, 1, 1); e = exp_q.pop_front(); end
        checks++;
        if ({h10, h1} !== 8'h23) begin
            errors++; $display("FAIL hours_23: got %h exp 23", {h10, h1});
        end
        step(0, 1, 1); e = exp_q.pop_front();
        checks++;
        if ({h10, h1, m10, m1} !== 16'h0000 || dut_vec !== e) begin
            errors++; $display("FAIL hours_wrap: got %h exp %h", dut_vec, e);
        end
        for (int i = 0; i < 5; i++) begin step(0, 1, 1); e = exp_q.pop_front(); end
        step(1, 1, 1); e = exp_q.pop_front();
        checks++;
        if ({mode, h10, h1} !== 11'h205 || dut_vec !== e) begin
            errors++; $display("FAIL simultaneous: got %h exp %h", dut_vec, e);
        end
        for (int i = 0; i < 59; i++) begin step(0, 1, 1); e = exp_q.pop_front(); end
        checks++;
        if ({m10, m1} !== 8'h59) begin
            errors++; $display("FAIL minutes_59: got %h exp 59", {m10, m1});
        end
        step(0, 1, 1); e = exp_q.pop_front();
        checks++;
        if ({h10, h1, m10, m1} !== 16'h0500 || dut_vec !== e) begin
            errors++; $display("FAIL minutes_wrap: got %h exp %h", dut_vec, e);
        end
        step(1, 0, 1); e = exp_q.pop_front();
        checks++;
        if (dut_vec !== e) begin
            errors++; $display("FAIL back_to_run: got %h exp %h", dut_vec, e);
        end
    endtask

    task automatic test_blink();
        logic [29:0] e;
        for (int i = 0; i < 8; i++) begin
            step(i == 0, 0, 1);
            e = exp_q.pop_front();
            checks++;
            if ({blank_h, blank_m} !== {(((i / BD) % 2) == 1), 1'b0} || dut_vec !== e) begin
                errors++; $display("FAIL blink_h cyc %0d: got %h exp %h", i, dut_vec, e);
            end
        end
        step(0, 1, 1); e = exp_q.pop_front();
        checks++;
        if (blank_h !== 1'b0 || dut_vec !== e) begin
            errors++; $display("FAIL blink_inc: got %h exp %h", dut_vec, e);
        end
        step(1, 0, 1); e = exp_q.pop_front();
        step(0, 0, 1); e = exp_q.pop_front();
        step(0, 0, 1); e = exp_q.pop_front();
        checks++;
        if ({blank_h, blank_m} !== 2'b01 || dut_vec !== e) begin
            errors++; $display("FAIL blink_m: got %h exp %h", dut_vec, e);
        end
        step(1, 0, 1); e = exp_q.pop_front();
        checks++;
        if ({mode, blank_h, blank_m} !== 5'b00000 || dut_vec !== e) begin
            errors++; $display("FAIL blink_run: got %h exp %h", dut_vec, e);
        end
    endtask

    task automatic test_tps1();
        logic [29:0] e;
        int prev, cur;
        prev = t1_s10 * 10 + t1_s1;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 1);
            e = exp_q.pop_front();
            cur = t1_s10 * 10 + t1_s1;
            checks++;
            if (t1_tick !== 1'b1 || cur != (prev + 1) % 60) begin
                errors++; $display("FAIL tps1 cyc %0d: got tick %b sec %0d exp tick 1 sec %0d",
                                   i, t1_tick, cur, (prev + 1) % 60);
            end
            prev = cur;
            checks++;
            if (dut_vec !== e) begin
                errors++; $display("FAIL tps1_main cyc %0d: got %h exp %h", i, dut_vec, e);
            end
        end
    endtask

    task automatic test_random();
        logic [29:0] e;
        bit bm, bi, rv;
        for (int i = 0; i < 400; i++) begin
            bm = ($urandom_range(0, 15) == 0);
            bi = ($urandom_range(0, 2) == 0);
            rv = ($urandom_range(0, 199) != 0);
            step(bm, bi, rv);
            e = exp_q.pop_front();
            checks++;
            if (dut_vec !== e) begin
                errors++; $display("FAIL random cyc %0d: got %h exp %h", i, dut_vec, e);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        t1_zero  = 1'b0;
        rst      = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        m_time = 0; m_mode = 0; m_since = 0; m_age = 0; m_tick = 0;
        test_reset();
        test_reset_mid_count();
        test_rollover();
        test_field_wrap();
        test_blink();
        test_tps1();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
- Timekeeping and time-set controller for the digital clock.
- Holds the six BCD time digits (HH:MM:SS, 24 h) and advances them from an internal seconds prescaler.
- Runs a mode FSM driven by one-cycle button pulses, so the user can set hours and minutes.
- Drives display digits and blanking masks for the seven-segment mux.

Parameters:
- TICKS_PER_SEC, 1, in_clk cycles per second; legal range is at least 1.
- BLINK_DIV, 2, in_clk cycles per half-period of the set-mode blink phase; legal range is at least 1.

Ports:
- in_clk  input  1  system clock
- rst  input  1  reset, synchronous, active-low
- btn_mode  input  1  one-cycle pulse, advances the mode FSM
- btn_inc  input  1  one-cycle pulse, increments the selected field
- h10  output  4  hours tens, BCD 0-2
- h1  output  4  hours ones, BCD 0-9
- m10  output  4  minutes tens, BCD 0-5
- m1  output  4  minutes ones, BCD 0-9
- s10  output  4  seconds tens, BCD 0-5
- s1  output  4  seconds ones, BCD 0-9
- mode  output  3  current FSM state encoding
- sec_tick  output  1  one-cycle pulse, registered with the second advance
- blank_h  output  1  high means the display blanks the hour digits
- blank_m  output  1  high means the display blanks the minute digits
- alarm  output  1  alarm pulse; exists only with ALARM_EN

Behaviour:
- One clock, in_clk. Reset is synchronous and active-low: rst is sampled only on the in_clk rising edge.
- Reset values, all outputs 0:
  - time 00:00:00
  - mode RUN (0)
  - prescaler 0, blink phase 0
  - sec_tick, blank_h, blank_m, alarm all 0
- Reset has priority over every other input on the same edge.
- FSM states: RUN=0, SET_H=1, SET_M=2. With ALARM_EN also SET_AH=3, SET_AM=4.
- btn_mode transitions:
  - RUN to SET_H to SET_M to RUN.
  - With ALARM_EN: SET_M to SET_AH to SET_AM to RUN.
- Entering SET_H: s10/s1 are cleared to 00 on the same edge, and the prescaler clears.
- In any SET state:
  - prescaler held at 0, no sec_tick, time frozen except by btn_inc.
- Returning to RUN: prescaler restarts from 0, so the first sec_tick comes TICKS_PER_SEC cycles after the edge that entered RUN.
- RUN prescaler and second advance:
  - Prescaler counts 0 to TICKS_PER_SEC-1.
  - On the edge where the count is TICKS_PER_SEC-1: prescaler goes to 0, seconds advance, and sec_tick is 1 for exactly that following cycle.
  - With TICKS_PER_SEC=1, sec_tick is 1 every cycle.
- Carry chain is BCD:
  - s1 9 to 0 carries into s10; s10 5 to 0 carries into m1; and likewise through m1, m10 and the hours.
  - Hours wrap 23 to 00.
  - 23:59:59 goes to 00:00:00 in one edge.
- btn_inc:
  - SET_H: hours +1, 23 wraps to 00.
  - SET_M: minutes +1, 59 wraps to 00.
  - In neither case is there a carry into any other field.
  - Ignored in RUN.
- Simultaneous btn_mode and btn_inc on one edge: btn_mode wins and btn_inc is discarded.
- Button effects are visible on the outputs the cycle after the sampling edge; all outputs are registered.
- Blink:
  - The phase toggles every BLINK_DIV cycles while in a SET state.
  - The phase is forced to 0 in RUN and on every mode change.
  - blank_h = phase AND (SET_H or SET_AH); blank_m = phase AND (SET_M or SET_AM).
  - A btn_inc forces phase 0 and restarts the blink counter, so the new value is shown immediately.
- Digits are never outside their BCD range. Internal invariants: h10 never exceeds 2, and h10=2 implies h1 does not exceed 3.

Optional Feature:
- Macro ALARM_EN.
- Defined:
  - Adds alarm_h and alarm_m BCD registers, reset to 00:00.
  - Adds states SET_AH and SET_AM. btn_inc increments alarm_h or alarm_m with the same wrap rules as the time fields.
  - While in a SET_A* state, outputs h10..m1 show the alarm value instead of the time.
  - alarm is a one-cycle pulse on the cycle after the time advances to HH:MM:00 where HH:MM equals the alarm, in RUN only.
  - alarm resets to 0.
- Not defined:
  - No alarm port, no alarm registers.
  - FSM has 3 states; mode never exceeds 2.

Test Plan:
- Reset mid-count: TICKS_PER_SEC=4, run to 00:00:03, assert rst low for 1 edge -> all digits 0, mode 0, sec_tick 0 the next cycle, first sec_tick 4 cycles after rst returns high.
- Full rollover: TICKS_PER_SEC=1, set 23:59 via SET_H ×23 inc and SET_M ×59 inc, return to RUN, wait 59 ticks -> 23:59:59, next tick -> 00:00:00 with sec_tick=1.
- Field wrap without carry: SET_M at 59, btn_inc -> m10=0, m1=0, hours unchanged; SET_H at 23, btn_inc -> 00.
- Simultaneous buttons: in SET_H with hours=05, btn_mode and btn_inc together -> mode=2, hours remain 05.
- Blink: BLINK_DIV=2, enter SET_H -> blank_h toggles every 2 cycles and blank_m stays 0; btn_inc -> blank_h=0 next cycle; RUN -> blank_h=blank_m=0.
- ALARM_EN: alarm=00:01, time 00:00:58, RUN -> alarm pulses exactly 1 cycle after the advance to 00:01:00; no pulse while in SET modes.
